// File: rtl/turbo_pkg.sv
// Constants, state encodings and helpers shared by the turbo input buffer and the encoder FSM.
// ADDR_W must cover LEN_LONG (2**ADDR_W >= LEN_LONG) so a bank address never wraps.
package turbo_pkg;

  localparam int LEN_SHORT = 1000;
  localparam int LEN_LONG  = 6000;
  localparam int ADDR_W    = 13;

  // One bit wider than a bank address so a length of exactly 2**ADDR_W still fits.
  typedef logic [ADDR_W:0] len_t;

  typedef enum logic {
    WR_IDLE,
    WR_FILL
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_START,
    RD_STREAM,
    RD_DRAIN
  } rd_state_e;

  function automatic len_t len_of(input logic flag);
    return flag ? len_t'(LEN_LONG) : len_t'(LEN_SHORT);
  endfunction

endpackage

// File: rtl/tib_bank_ram.sv
// Simple dual-port 1-bit RAM holding both ping-pong banks; the bank index is the address MSB.
// Synchronous write port and a registered read port (one cycle of read latency).
module tib_bank_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic          mem [2**AW];
  logic          rdata_q;

  // NOTE: the storage array and read register carry no reset, so the array maps onto
  // block RAM; bank validity is tracked by the full flags in the parent, not by contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/turbo_input_buffer.sv
// Ping-pong block buffer feeding the turbo encoder: the write FSM fills one bank from the
// serial stream while the read FSM starts the encoder and streams the other bank into it.
module turbo_input_buffer
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_sop,
  input  logic in_size_flag,
  output logic in_ready,
  input  logic enc_idle,
  output logic data_valid,
  output logic length_flag,
  output logic enc_bit,
  output logic enc_bit_valid,
  output logic enc_last,
  output logic sop_err
);

  // Write side state
  wr_state_e         wr_state_q, wr_state_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              sop_err_q, sop_err_d;

  // Per-bank status, written by both FSMs (never for the same bank in one cycle)
  logic [1:0]        full_q, full_d;
  logic [1:0]        flag_q, flag_d;

  // Read side state
  rd_state_e         rd_state_q, rd_state_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              length_flag_q, length_flag_d;

  // RAM interface
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr_lo;
  logic [ADDR_W-1:0] ram_raddr_lo;
  logic              ram_rdata;

  logic              set_full;
  logic              clr_full;
  logic              rd_last;

  assign rd_last = (rd_state_q == RD_STREAM) &&
                   ({1'b0, rd_cnt_q} == len_of(length_flag_q) - 1'b1);

  // NOTE: every signal driven here gets a default before the case, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_addr_d    = wr_addr_q;
    flag_d       = flag_q;
    sop_err_d    = 1'b0;
    set_full     = 1'b0;
    ram_we       = 1'b0;
    ram_waddr_lo = wr_addr_q;

    unique case (wr_state_q)
      WR_IDLE: begin
        // A beat without sop here is dropped; a sop waits for an empty bank.
        if (in_valid && in_sop && !full_q[wr_ptr_q]) begin
          ram_we           = 1'b1;
          ram_waddr_lo     = '0;
          flag_d[wr_ptr_q] = in_size_flag;
          wr_addr_d        = ADDR_W'(1);
          wr_state_d       = WR_FILL;
        end
      end
      WR_FILL: begin
        if (in_valid) begin
          ram_we = 1'b1;
          if (in_sop) begin
            sop_err_d        = 1'b1;
            ram_waddr_lo     = '0;
            flag_d[wr_ptr_q] = in_size_flag;
            wr_addr_d        = ADDR_W'(1);
          end else if ({1'b0, wr_addr_q} == len_of(flag_q[wr_ptr_q]) - 1'b1) begin
            set_full   = 1'b1;
            wr_ptr_d   = ~wr_ptr_q;
            wr_addr_d  = '0;
            wr_state_d = WR_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_ptr_d      = rd_ptr_q;
    rd_cnt_d      = rd_cnt_q;
    length_flag_d = length_flag_q;
    clr_full      = 1'b0;
    // Prefetch the next bit so it leaves the registered read port one cycle later.
    ram_raddr_lo  = rd_cnt_q + 1'b1;

    unique case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_ptr_q] && enc_idle) begin
          length_flag_d = flag_q[rd_ptr_q];
          rd_state_d    = RD_START;
        end
      end
      RD_START: begin
        ram_raddr_lo = '0;
        rd_cnt_d     = '0;
        rd_state_d   = RD_STREAM;
      end
      RD_STREAM: begin
        if (rd_last) begin
          clr_full   = 1'b1;
          rd_ptr_d   = ~rd_ptr_q;
          rd_state_d = RD_DRAIN;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      RD_DRAIN: begin
        // The encoder is still terminating the previous block.
        if (enc_idle) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (set_full) begin
      full_d[wr_ptr_q] = 1'b1;
    end
    if (clr_full) begin
      full_d[rd_ptr_q] = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q    <= WR_IDLE;
      wr_ptr_q      <= 1'b0;
      wr_addr_q     <= '0;
      sop_err_q     <= 1'b0;
      full_q        <= '0;
      flag_q        <= '0;
      rd_state_q    <= RD_IDLE;
      rd_ptr_q      <= 1'b0;
      rd_cnt_q      <= '0;
      length_flag_q <= 1'b0;
    end else begin
      wr_state_q    <= wr_state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_addr_q     <= wr_addr_d;
      sop_err_q     <= sop_err_d;
      full_q        <= full_d;
      flag_q        <= flag_d;
      rd_state_q    <= rd_state_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_cnt_q      <= rd_cnt_d;
      length_flag_q <= length_flag_d;
    end
  end

  tib_bank_ram #(
    .AW (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i ({wr_ptr_q, ram_waddr_lo}),
    .wdata_i (in_bit),
    .raddr_i ({rd_ptr_q, ram_raddr_lo}),
    .rdata_o (ram_rdata)
  );

  assign in_ready      = !((wr_state_q == WR_IDLE) && full_q[wr_ptr_q]);
  assign data_valid    = (rd_state_q == RD_START);
  assign length_flag   = length_flag_q;
  assign enc_bit_valid = (rd_state_q == RD_STREAM);
  assign enc_bit       = enc_bit_valid && ram_rdata;
  assign enc_last      = rd_last;
  assign sop_err       = sop_err_q;

endmodule

// File: tb/tb_turbo_input_buffer.sv
// Directed bench for turbo_input_buffer: drives blocks, models encoder idle/busy timing,
// records every stream and compares it with the bits that were sent.
module tb_turbo_input_buffer;
  import turbo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_sop = 1'b0;
  logic in_size_flag = 1'b0;
  logic enc_idle;
  logic in_ready, data_valid, length_flag, enc_bit, enc_bit_valid, enc_last, sop_err;

  always #5 clk = ~clk;

  turbo_input_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_bit        (in_bit),
    .in_sop        (in_sop),
    .in_size_flag  (in_size_flag),
    .in_ready      (in_ready),
    .enc_idle      (enc_idle),
    .data_valid    (data_valid),
    .length_flag   (length_flag),
    .enc_bit       (enc_bit),
    .enc_bit_valid (enc_bit_valid),
    .enc_last      (enc_last),
    .sop_err       (sop_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Driven by the main sequence only
  logic enc_en = 1'b0;
  int   enc_tail = 0;
  int   test_id = 0;
  int   ready_waits = 0;
  bit   exp_q[$];

  // Driven by the monitor / encoder model only
  logic enc_busy = 1'b0;
  logic draining = 1'b0;
  int   tail_cnt = 0;
  int   seen_id = 0;
  int   dv_cnt, dv_busy, gap_cnt, lf_err, sop_err_cnt, cur_len, prev_cyc, rise_cyc;
  logic ready_prev = 1'b1;
  bit   bits_q[$];
  int   lens_q[$], dv_cyc_q[$], off_q[$], last_cyc_q[$], flags_q[$];

  assign enc_idle = enc_en && !enc_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (test_id != seen_id) begin
      seen_id = test_id;
      dv_cnt = 0; dv_busy = 0; gap_cnt = 0; lf_err = 0; sop_err_cnt = 0;
      cur_len = 0; prev_cyc = 0; rise_cyc = -1; ready_prev = in_ready;
      bits_q.delete(); lens_q.delete(); dv_cyc_q.delete();
      off_q.delete(); last_cyc_q.delete(); flags_q.delete();
    end
    if (data_valid) begin
      dv_cnt++;
      dv_cyc_q.push_back(cyc);
      flags_q.push_back(int'(length_flag));
      if (!enc_idle) dv_busy++;
      cur_len = 0;
    end
    if (enc_bit_valid) begin
      if (cur_len == 0) begin
        if (dv_cyc_q.size() > 0) off_q.push_back(cyc - dv_cyc_q[dv_cyc_q.size()-1]);
        else off_q.push_back(-1);
      end else if (prev_cyc != cyc - 1) begin
        gap_cnt++;
      end
      if (flags_q.size() == 0 || int'(length_flag) != flags_q[flags_q.size()-1]) lf_err++;
      bits_q.push_back(enc_bit);
      cur_len++;
      prev_cyc = cyc;
      if (enc_last) begin
        lens_q.push_back(cur_len);
        last_cyc_q.push_back(cyc);
        cur_len = 0;
      end
    end
    if (sop_err) sop_err_cnt++;
    if (in_ready && !ready_prev) rise_cyc = cyc;
    ready_prev = in_ready;
    // Encoder model: busy from data_valid until enc_tail cycles after enc_last
    if (reset) begin
      enc_busy = 1'b0;
      draining = 1'b0;
    end else if (data_valid) begin
      enc_busy = 1'b1;
    end else if (draining) begin
      tail_cnt--;
      if (tail_cnt <= 0) begin
        enc_busy = 1'b0;
        draining = 1'b0;
      end
    end else if (enc_busy && enc_last) begin
      if (enc_tail == 0) enc_busy = 1'b0;
      else begin
        tail_cnt = enc_tail;
        draining = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qi(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic bit pat(input int seed, input int i);
    if (seed == 0) return bit'(i & 1);
    return ((i * 13 + seed) % 7) < 3;
  endfunction

  task automatic new_test();
    test_id++;
    exp_q.delete();
    ready_waits = 0;
    tick();
  endtask

  task automatic send_block(input bit flag, input int n, input int seed, input bit rec);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (!in_ready && guard < 20000) begin
        in_valid = 1'b0;
        tick();
        guard++;
        ready_waits++;
      end
      if (guard >= 20000) check("in_ready_timeout", 0, 1);
      in_valid     = 1'b1;
      in_sop       = (i == 0);
      in_size_flag = flag;
      in_bit       = pat(seed, i);
      if (rec) exp_q.push_back(in_bit);
      tick();
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic wait_streams(input int n, input int budget, input string tag);
    int k = 0;
    while (lens_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, lens_q.size(), n);
  endtask

  task automatic check_bits(input string tag, input bit full_len);
    int mism = 0;
    int n = (bits_q.size() < exp_q.size()) ? bits_q.size() : exp_q.size();
    if (full_len) check({tag, "_count"}, bits_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (bits_q[i] != exp_q[i]) mism++;
    check({tag, "_data"}, mism, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_data_valid", data_valid, 0);
    check("rst_enc_bit_valid", enc_bit_valid, 0);
    check("rst_enc_last", enc_last, 0);
    check("rst_sop_err", sop_err, 0);
    check("rst_length_flag", length_flag, 0);
    check("rst_enc_bit", enc_bit, 0);
    reset = 1'b0;
    tick();

    // Short block, encoder idle
    new_test();
    enc_en = 1'b1;
    enc_tail = 0;
    send_block(1'b0, LEN_SHORT, 0, 1'b1);
    wait_streams(1, 3000, "t1_streams");
    check("t1_dv_cnt", dv_cnt, 1);
    check("t1_flag", qi(flags_q, 0), 0);
    check("t1_len", qi(lens_q, 0), 1000);
    check("t1_offset", qi(off_q, 0), 1);
    check("t1_gaps", gap_cnt, 0);
    check("t1_lf_stable", lf_err, 0);
    check_bits("t1_bits", 1'b1);

    // Ping-pong: long block then short, encoder busy 200 cycles after first stream
    new_test();
    enc_tail = 200;
    send_block(1'b1, LEN_LONG, 1, 1'b1);
    send_block(1'b0, LEN_SHORT, 2, 1'b1);
    check("t2_ready_waits", ready_waits, 0);
    wait_streams(2, 10000, "t2_streams");
    check("t2_dv_cnt", dv_cnt, 2);
    check("t2_flag0", qi(flags_q, 0), 1);
    check("t2_flag1", qi(flags_q, 1), 0);
    check("t2_len0", qi(lens_q, 0), 6000);
    check("t2_len1", qi(lens_q, 1), 1000);
    check("t2_dv2_delay", qi(dv_cyc_q, 1) - qi(last_cyc_q, 0), 202);
    check("t2_offset1", qi(off_q, 1), 1);
    check("t2_dv_busy", dv_busy, 0);
    check("t2_gaps", gap_cnt, 0);
    check("t2_lf_stable", lf_err, 0);
    check_bits("t2_bits", 1'b1);
    enc_tail = 0;

    // Backpressure: two banks fill while the encoder is held busy
    new_test();
    enc_en = 1'b0;
    send_block(1'b0, LEN_SHORT, 3, 1'b1);
    send_block(1'b0, LEN_SHORT, 4, 1'b1);
    check("t3_ready_low", in_ready, 0);
    repeat (5) tick();
    check("t3_ready_still_low", in_ready, 0);
    check("t3_no_dv", dv_cnt, 0);
    enc_en = 1'b1;
    send_block(1'b0, LEN_SHORT, 5, 1'b1);
    check("t3_ready_rise", rise_cyc, qi(last_cyc_q, 0) + 1);
    wait_streams(3, 4000, "t3_streams");
    check("t3_dv_cnt", dv_cnt, 3);
    check("t3_len2", qi(lens_q, 2), 1000);
    check("t3_dv_busy", dv_busy, 0);
    check_bits("t3_bits", 1'b1);

    // Early sop: 500 bits of a short block, then a full long block
    new_test();
    send_block(1'b0, 500, 6, 1'b0);
    send_block(1'b1, LEN_LONG, 7, 1'b1);
    wait_streams(1, 8000, "t4_streams");
    repeat (50) tick();
    check("t4_sop_err", sop_err_cnt, 1);
    check("t4_dv_cnt", dv_cnt, 1);
    check("t4_len", qi(lens_q, 0), 6000);
    check("t4_flag", qi(flags_q, 0), 1);
    check_bits("t4_bits", 1'b1);

    // Reset in the middle of a stream
    new_test();
    send_block(1'b0, LEN_SHORT, 8, 1'b1);
    begin
      int k = 0;
      while (bits_q.size() < 300 && k < 3000) begin
        tick();
        k++;
      end
    end
    check("t5_reached_300", int'(bits_q.size() >= 300), 1);
    reset = 1'b1;
    tick();
    check("t5_dv_after_rst", data_valid, 0);
    check("t5_valid_after_rst", enc_bit_valid, 0);
    check("t5_last_after_rst", enc_last, 0);
    check("t5_ready_after_rst", in_ready, 1);
    tick();
    reset = 1'b0;
    nb = bits_q.size();
    repeat (1200) tick();
    check("t5_dv_cnt", dv_cnt, 1);
    check("t5_no_complete", lens_q.size(), 0);
    check("t5_no_more_bits", bits_q.size(), nb);
    check_bits("t5_prefix", 1'b0);

    // Stray beats without sop are dropped
    new_test();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_sop   = 1'b0;
      in_bit   = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    check("t6_no_dv", dv_cnt, 0);
    check("t6_ready", in_ready, 1);
    send_block(1'b0, LEN_SHORT, 9, 1'b1);
    wait_streams(1, 3000, "t6_streams");
    check("t6_sop_err", sop_err_cnt, 0);
    check("t6_len", qi(lens_q, 0), 1000);
    check_bits("t6_bits", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/turbo_input_buffer.md
Name: turbo_input_buffer

Overview:
- Ping-pong input block buffer directly upstream of the turbo encoder control FSM.
- Accepts a serial information-bit stream in blocks of 1000 or 6000 bits and stores each complete block in one of two banks.
- Issues the one-cycle data_valid start pulse with length_flag, then streams the block bit-contiguously into the encoder.
- The encoder is only started when it reports idle; the write side keeps filling the other bank meanwhile.

Parameters:
- LEN_SHORT, 1000, block length when size flag = 0
- LEN_LONG, 6000, block length when size flag = 1
- ADDR_W, 13, per-bank address width; must satisfy 2^ADDR_W >= LEN_LONG

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_bit valid this cycle
- in_bit  in  1  information bit
- in_sop  in  1  first bit of a block; qualified by in_valid
- in_size_flag  in  1  block size for this block (0 = LEN_SHORT, 1 = LEN_LONG); sampled on the sop beat
- in_ready  out  1  a bank is free or currently filling; upstream must not drive in_valid while low
- enc_idle  in  1  encoder FSM is in WAIT
- data_valid  out  1  one-cycle start pulse to the encoder
- length_flag  out  1  size flag of the block being streamed; held stable from the data_valid cycle to the end of the stream
- enc_bit  out  1  streamed information bit
- enc_bit_valid  out  1  enc_bit valid
- enc_last  out  1  final bit of the block
- sop_err  out  1  one-cycle pulse when a fill is aborted by an early sop

Behaviour:
- Reset values: all outputs 0 except in_ready = 1. Both banks empty. Write and read bank pointers = 0. Both FSMs idle.
- Reset mid-operation discards both banks and any stream in progress. enc_bit_valid drops the cycle after reset is seen.
- Write FSM states:
  - WR_IDLE: on in_valid && in_sop, if the write bank is empty, store the bit at address 0, latch in_size_flag into the bank's flag, and go to WR_FILL with addr = 1. in_valid without in_sop in WR_IDLE: bit dropped silently.
  - WR_FILL: each in_valid stores at addr, then addr++. On storing address L-1 (L from the latched flag), mark the bank full, toggle the write pointer, and go to WR_IDLE.
  - Early sop in WR_FILL (addr < L): pulse sop_err, restart at address 0 in the same bank with the new flag, and stay in WR_FILL.
- in_ready = 0 only when the write FSM is in WR_IDLE and the bank under the write pointer is full.
- Read FSM states:
  - RD_IDLE: when the read bank is full and enc_idle = 1, go to RD_START.
  - RD_START: assert data_valid for exactly 1 cycle, drive length_flag from the bank flag, and issue RAM read address 0.
  - RD_STREAM: the RAM has 1-cycle registered-read latency. enc_bit_valid = 1 for exactly L consecutive cycles, starting the cycle after data_valid. Bit k appears k+1 cycles after data_valid. enc_last is asserted with bit L-1.
  - End of stream: the cycle after enc_last, mark the bank empty, toggle the read pointer, and go to RD_DRAIN.
  - RD_DRAIN: wait until enc_idle = 1 (the encoder is still finishing ENCODE/TERMINATE), then return to RD_IDLE.
  - data_valid is never issued while enc_idle = 0.
- Simultaneous events:
  - A bank freed by the read side in the same cycle the write side needs it: the write side sees it as free one cycle later; no bit may be lost because in_ready was already low.
  - The write side completing a bank while the read side is in RD_IDLE: read start is eligible the next cycle.
- Addresses are unsigned ADDR_W bits. The bank index is concatenated as the RAM address MSB. No wrap-around within a bank is possible because L <= 2^ADDR_W.

Decomposition:
- Shared package turbo_pkg holds:
  - LEN_SHORT, LEN_LONG, ADDR_W, shared with the encoder FSM
  - write-state and read-state enums
  - the function len_of(flag)
- One sub-module: tib_bank_ram, a simple dual-port 1-bit x 2^(ADDR_W+1) RAM with a synchronous write port and a registered read port.

Test Plan:
- Short block: sop with flag = 0, then 1000 bits of an alternating pattern, enc_idle = 1 → data_valid 1 cycle; length_flag = 0; 1000 contiguous enc_bit_valid cycles starting at +1; enc_last on the 1000th; bits match the input.
- Ping-pong: a 6000-bit block followed immediately by a 1000-bit block, with enc_idle held low for 200 cycles after the first stream → in_ready stays 1 throughout; the second data_valid waits for enc_idle; the second block streams with length_flag = 0.
- Backpressure: three back-to-back blocks with enc_idle = 0 → in_ready goes 0 after the second block completes; raising enc_idle starts the first stream, and in_ready returns to 1 only after that stream ends.
- Early sop: sop plus 500 bits, then a new sop with flag = 1 plus 6000 bits → sop_err pulses once; exactly one 6000-bit stream is produced, holding the second block's data.
- Reset mid-stream at bit 300 → data_valid and enc_bit_valid are 0 the cycle after; in_ready = 1; no stream occurs afterwards without new input.
- Stray data: in_valid without sop in WR_IDLE for 10 cycles → no bank is filled and no data_valid is issued.
